// File: rtl/reg_bus_pkg.sv
// Shared definitions for the two-requester register-bus arbiter.
//   arb_state_t : FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   NUM_REQ     : number of requesters sharing the register bus
//   rr_pick     : round-robin winner selection for two requesters
package reg_bus_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Returns the index of the winning requester. Only a tie consults the
  // last-grant pointer; a lone request always wins. The result is don't-care
  // when no request is present.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] req, input logic last);
    if (req[0] && req[1]) return ~last;
    return req[1] & ~req[0];
  endfunction

endpackage

// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single register bus.
// A granted command is latched, issued for one cycle, then the bus response
// (or a forced timeout error) is returned to the winner as a one-cycle ack.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   m_req/m_is_wr     per-requester request and write flag (bit i = requester i)
//   m_addr/m_wr_data/m_wr_biten  per-requester command, packed requester-major
//   m_ack             one-cycle completion strobe per requester
//   m_rd_data/m_err   response data and error, valid with m_ack
//   o_bus_*           register-bus command, non-zero only during ISSUE
//   bus_ready/bus_rd_data/bus_err  register-bus response
//   busy              high whenever a transaction is in progress
//   timeout_pulse     one-cycle strobe, coincident with the ack of a timed-out access
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              m_req,
  input  logic [NUM_REQ-1:0]              m_is_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   m_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   m_wr_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   m_wr_biten,
  output logic [NUM_REQ-1:0]              m_ack,
  output logic [DATA_WIDTH-1:0]           m_rd_data,
  output logic                            m_err,
  output logic                            o_bus_req,
  output logic                            o_bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]           o_bus_addr,
  output logic [DATA_WIDTH-1:0]           o_bus_wr_data,
  output logic [DATA_WIDTH-1:0]           o_bus_wr_biten,
  input  logic                            bus_ready,
  input  logic [DATA_WIDTH-1:0]           bus_rd_data,
  input  logic                            bus_err,
  output logic                            busy,
  output logic                            timeout_pulse
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  arb_state_t              r_state;
  arb_state_t              w_next;

  logic                    w_win;
  logic                    r_grant;
  logic                    r_last;
  logic                    r_is_wr;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [DATA_WIDTH-1:0]   r_wr_biten;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_err;
  logic                    r_to;
  logic                    w_limit;

  assign w_win   = rr_pick(m_req, r_last);
  assign w_limit = (r_cnt == CNT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    w_next          = r_state;
    m_ack           = '0;
    m_rd_data       = '0;
    m_err           = 1'b0;
    o_bus_req       = 1'b0;
    o_bus_req_is_wr = 1'b0;
    o_bus_addr      = '0;
    o_bus_wr_data   = '0;
    o_bus_wr_biten  = '0;
    timeout_pulse   = 1'b0;
    busy            = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (|m_req) w_next = ISSUE;
      end
      ISSUE: begin
        o_bus_req       = 1'b1;
        o_bus_req_is_wr = r_is_wr;
        o_bus_addr      = r_addr;
        o_bus_wr_data   = r_wr_data;
        o_bus_wr_biten  = r_wr_biten;
        w_next          = WAIT;
      end
      WAIT: begin
        // A ready on the limit cycle also exits here; the datapath gives it priority.
        if (bus_ready || w_limit) w_next = RESP;
      end
      RESP: begin
        m_ack         = r_grant ? 2'b10 : 2'b01;
        m_rd_data     = r_rd_data;
        m_err         = r_err;
        timeout_pulse = r_to;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_wr_biten <= '0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
      r_to       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|m_req) begin
            r_grant    <= w_win;
            r_is_wr    <= w_win ? m_is_wr[1] : m_is_wr[0];
            r_addr     <= w_win ? m_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                : m_addr[0 +: ADDR_WIDTH];
            r_wr_data  <= w_win ? m_wr_data[DATA_WIDTH +: DATA_WIDTH]
                                : m_wr_data[0 +: DATA_WIDTH];
            r_wr_biten <= w_win ? m_wr_biten[DATA_WIDTH +: DATA_WIDTH]
                                : m_wr_biten[0 +: DATA_WIDTH];
          end
        end
        ISSUE: begin
          r_cnt <= '0;
        end
        WAIT: begin
          if (bus_ready) begin
            r_rd_data <= r_is_wr ? '0 : bus_rd_data;
            r_err     <= bus_err;
            r_to      <= 1'b0;
          end else if (w_limit) begin
            r_rd_data <= '0;
            r_err     <= 1'b1;
            r_to      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_last <= r_grant;
        end
        default: ;
      endcase
    end
  end

endmodule
